// File: rtl/sdram_bridge_pkg.sv
// Shared definitions for the AXI4-to-APB bridge in front of the SDRAM
// controller wrapper: FSM state encoding plus AXI burst/response codes.
package sdram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_BRESP,
        ST_RDATA
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for an AXI burst.
// Ports: addr (current beat address), size (log2 bytes per beat),
//        burst (AXI burst type), next_addr (address of the following beat).
// FIXED holds the address; every other encoding (WRAP and reserved
// included) steps linearly by the beat size and rolls over at 2^ADDR_W.
module axi_addr_gen
    import sdram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    always_comb begin
        if (burst == BURST_FIXED) next_addr = addr;
        else                      next_addr = addr + (ADDR_W'(1) << size);
    end

endmodule

// File: rtl/sdram_axi4_apb_bridge.sv
// AXI4 slave to APB master bridge. One AXI transaction in flight at a time;
// every beat becomes exactly one APB transfer.
// Ports:
//   clock, reset (async, active low)
//   in_aw*/in_w*/in_b*  AXI write address / data / response channels
//   in_ar*/in_r*        AXI read address / data channels
//   out_p*              APB master (psel/penable/pwrite/paddr/pprot/pwdata/
//                       pstrb out; pready/pslverr/prdata in)
module sdram_axi4_apb_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_awvalid,
    output logic              in_awready,
    input  logic [ID_W-1:0]   in_awid,
    input  logic [ADDR_W-1:0] in_awaddr,
    input  logic [7:0]        in_awlen,
    input  logic [2:0]        in_awsize,
    input  logic [1:0]        in_awburst,
    input  logic [2:0]        in_awprot,
    input  logic              in_wvalid,
    output logic              in_wready,
    input  logic [31:0]       in_wdata,
    input  logic [3:0]        in_wstrb,
    input  logic              in_wlast,
    output logic              in_bvalid,
    input  logic              in_bready,
    output logic [ID_W-1:0]   in_bid,
    output logic [1:0]        in_bresp,
    input  logic              in_arvalid,
    output logic              in_arready,
    input  logic [ID_W-1:0]   in_arid,
    input  logic [ADDR_W-1:0] in_araddr,
    input  logic [7:0]        in_arlen,
    input  logic [2:0]        in_arsize,
    input  logic [1:0]        in_arburst,
    input  logic [2:0]        in_arprot,
    output logic              in_rvalid,
    input  logic              in_rready,
    output logic [ID_W-1:0]   in_rid,
    output logic [31:0]       in_rdata,
    output logic [1:0]        in_rresp,
    output logic              in_rlast,
    output logic              out_psel,
    output logic              out_penable,
    output logic              out_pwrite,
    output logic [ADDR_W-1:0] out_paddr,
    output logic [2:0]        out_pprot,
    output logic [31:0]       out_pwdata,
    output logic [3:0]        out_pstrb,
    input  logic              out_pready,
    input  logic              out_pslverr,
    input  logic [31:0]       out_prdata
);

    state_e              state_q, state_d;
    logic                last_was_write;
    logic                served_q;      // any grant since reset
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [7:0]          cnt_q;
    logic [2:0]          size_q, prot_q;
    logic [1:0]          burst_q;
    logic                wr_q;
    logic [31:0]         wdata_q, rdata_q;
    logic [3:0]          wstrb_q;
    logic                err_acc, rerr_q;
    logic                aw_win, ar_win;

    // Beat count comes from len; wlast carries no extra information.
    logic unused_wlast;
    assign unused_wlast = in_wlast;

    axi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (addr_nxt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Arbitration: on a tie the channel not served last wins. Until the first
    // grant the bridge behaves as if a write was served last, so AR goes first.
    // Gating with reset keeps both readies low while reset is held.
    always_comb begin
        state_d = state_q;
        aw_win  = 1'b0;
        ar_win  = 1'b0;
        if (state_q == ST_IDLE && reset) begin
            aw_win = in_awvalid && (!in_arvalid || (served_q && !last_was_write));
            ar_win = in_arvalid && !aw_win;
        end
        unique case (state_q)
            ST_IDLE:   if (aw_win)      state_d = ST_WDATA;
                       else if (ar_win) state_d = ST_SETUP;
            ST_WDATA:  if (in_wvalid)   state_d = ST_SETUP;
            ST_SETUP:                   state_d = ST_ACCESS;
            ST_ACCESS: if (out_pready) begin
                           if (!wr_q)             state_d = ST_RDATA;
                           else if (cnt_q != 8'd0) state_d = ST_WDATA;
                           else                   state_d = ST_BRESP;
                       end
            ST_RDATA:  if (in_rready)   state_d = (cnt_q != 8'd0) ? ST_SETUP : ST_IDLE;
            ST_BRESP:  if (in_bready)   state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_was_write <= 1'b0;
            served_q       <= 1'b0;
            id_q           <= '0;
            addr_q         <= '0;
            cnt_q          <= 8'd0;
            size_q         <= 3'd0;
            burst_q        <= 2'd0;
            prot_q         <= 3'd0;
            wr_q           <= 1'b0;
            wdata_q        <= 32'd0;
            wstrb_q        <= 4'd0;
            err_acc        <= 1'b0;
            rdata_q        <= 32'd0;
            rerr_q         <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (aw_win) begin
                        id_q    <= in_awid;    addr_q  <= in_awaddr;
                        cnt_q   <= in_awlen;   size_q  <= in_awsize;
                        burst_q <= in_awburst; prot_q  <= in_awprot;
                        wr_q    <= 1'b1;
                    end else if (ar_win) begin
                        id_q    <= in_arid;    addr_q  <= in_araddr;
                        cnt_q   <= in_arlen;   size_q  <= in_arsize;
                        burst_q <= in_arburst; prot_q  <= in_arprot;
                        wr_q    <= 1'b0;
                    end
                    if (aw_win || ar_win) begin
                        last_was_write <= aw_win;
                        served_q       <= 1'b1;
                        err_acc        <= 1'b0;
                    end
                end
                ST_WDATA: if (in_wvalid) begin
                    wdata_q <= in_wdata;
                    wstrb_q <= in_wstrb;
                end
                ST_ACCESS: if (out_pready) begin
                    if (wr_q) begin
                        err_acc <= err_acc | out_pslverr;
                        if (cnt_q != 8'd0) begin
                            addr_q <= addr_nxt;
                            cnt_q  <= cnt_q - 8'd1;
                        end
                    end else begin
                        rdata_q <= out_prdata;
                        rerr_q  <= out_pslverr;
                    end
                end
                ST_RDATA: if (in_rready && cnt_q != 8'd0) begin
                    addr_q <= addr_nxt;
                    cnt_q  <= cnt_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_awready  = aw_win;
    assign in_arready  = ar_win;
    assign in_wready   = (state_q == ST_WDATA);

    // APB side is decoded from registered state only; psel drops while an
    // R or B response is stalled.
    assign out_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign out_penable = (state_q == ST_ACCESS);
    assign out_pwrite  = wr_q;
    assign out_paddr   = addr_q;
    assign out_pprot   = prot_q;
    assign out_pwdata  = wdata_q;
    assign out_pstrb   = wr_q ? wstrb_q : 4'd0;

    assign in_rvalid   = (state_q == ST_RDATA);
    assign in_rid      = id_q;
    assign in_rdata    = rdata_q;
    assign in_rresp    = rerr_q ? RESP_SLVERR : RESP_OKAY;
    assign in_rlast    = (state_q == ST_RDATA) && (cnt_q == 8'd0);

    assign in_bvalid   = (state_q == ST_BRESP);
    assign in_bid      = id_q;
    assign in_bresp    = err_acc ? RESP_SLVERR : RESP_OKAY;

endmodule
